// File: rtl/tex_texel_fetch.sv
// Texel fetch: reads one VRAM halfword per request, optionally
// resolving a 4/8-bit palette index through a second CLUT read.
module tex_texel_fetch (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic [1:0]  GPU_REG_TexFormat,
    input  logic [5:0]  GPU_REG_CLUTX,
    input  logic [8:0]  GPU_REG_CLUTY,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [18:0] req_texelAdress,
    input  logic [1:0]  req_uSub,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [18:0] mem_adr,
    input  logic        mem_dvalid,
    input  logic [15:0] mem_data,
    output logic        texel_valid,
    input  logic        texel_ready,
    output logic [15:0] texel_color
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_TEX    = 3'd1;
    localparam logic [2:0] WAIT_TEX  = 3'd2;
    localparam logic [2:0] RD_CLUT   = 3'd3;
    localparam logic [2:0] WAIT_CLUT = 3'd4;
    localparam logic [2:0] OUT       = 3'd5;

    logic [2:0]  state;
    logic [18:0] texAdr;
    logic [1:0]  uSub;
    logic [1:0]  texFormat;
    logic [5:0]  clutX;
    logic [8:0]  clutY;
    logic [7:0]  clutIndex;
    logic [15:0] color;
    logic [7:0]  texIndex;
    logic [9:0]  clutCol;
    logic        isDirect;

    // Format 3 is reserved and behaves like direct 16-bit colour.
    assign isDirect = texFormat[1];
    assign clutCol  = {clutX, 4'd0} + {2'd0, clutIndex};

    always_comb begin
        texIndex = 8'd0;
        if (texFormat == 2'd0) begin
            texIndex = {4'd0, mem_data[{uSub, 2'b00} +: 4]};
        end else begin
            texIndex = uSub[0] ? mem_data[15:8] : mem_data[7:0];
        end
    end

    always_comb begin
        mem_adr = 19'd0;
        if (state == RD_TEX) begin
            mem_adr = texAdr;
        end else if (state == RD_CLUT) begin
            mem_adr = {clutY, clutCol};
        end
    end

    assign req_ready   = (state == IDLE);
    assign mem_req     = (state == RD_TEX) || (state == RD_CLUT);
    assign texel_valid = (state == OUT);
    assign texel_color = color;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            texAdr    <= 19'd0;
            uSub      <= 2'd0;
            texFormat <= 2'd0;
            clutX     <= 6'd0;
            clutY     <= 9'd0;
            clutIndex <= 8'd0;
            color     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        texAdr    <= req_texelAdress;
                        uSub      <= req_uSub;
                        texFormat <= GPU_REG_TexFormat;
                        clutX     <= GPU_REG_CLUTX;
                        clutY     <= GPU_REG_CLUTY;
                        state     <= RD_TEX;
                    end
                end
                RD_TEX: begin
                    if (mem_ack) state <= WAIT_TEX;
                end
                WAIT_TEX: begin
                    if (mem_dvalid) begin
                        if (isDirect) begin
                            color <= mem_data;
                            state <= OUT;
                        end else begin
                            clutIndex <= texIndex;
                            state     <= RD_CLUT;
                        end
                    end
                end
                RD_CLUT: begin
                    if (mem_ack) state <= WAIT_CLUT;
                end
                WAIT_CLUT: begin
                    if (mem_dvalid) begin
                        color <= mem_data;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (texel_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tex_texel_fetch.sv
// Directed bench for tex_texel_fetch with a hand-driven VRAM port.
module tb_tex_texel_fetch;

    logic        clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic [1:0]  GPU_REG_TexFormat = '0;
    logic [5:0]  GPU_REG_CLUTX = '0;
    logic [8:0]  GPU_REG_CLUTY = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [18:0] req_texelAdress = '0;
    logic [1:0]  req_uSub = '0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [18:0] mem_adr;
    logic        mem_dvalid = 1'b0;
    logic [15:0] mem_data = '0;
    logic        texel_valid;
    logic        texel_ready = 1'b1;
    logic [15:0] texel_color;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    tex_texel_fetch dut (
        .clk(clk),
        .i_nrst(i_nrst),
        .GPU_REG_TexFormat(GPU_REG_TexFormat),
        .GPU_REG_CLUTX(GPU_REG_CLUTX),
        .GPU_REG_CLUTY(GPU_REG_CLUTY),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_texelAdress(req_texelAdress),
        .req_uSub(req_uSub),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .mem_adr(mem_adr),
        .mem_dvalid(mem_dvalid),
        .mem_data(mem_data),
        .texel_valid(texel_valid),
        .texel_ready(texel_ready),
        .texel_color(texel_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Accept cycle counts as cycle 1; registers are scrambled afterwards.
    task automatic doReq(input string tag, input logic [1:0] fmt,
                         input logic [5:0] cx, input logic [8:0] cy,
                         input logic [18:0] adr, input logic [1:0] us);
        GPU_REG_TexFormat = fmt;
        GPU_REG_CLUTX = cx;
        GPU_REG_CLUTY = cy;
        req_texelAdress = adr;
        req_uSub = us;
        req_valid = 1'b1;
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        cyc = 1;
        tick();
        req_valid = 1'b0;
        GPU_REG_TexFormat = ~fmt;
        GPU_REG_CLUTX = ~cx;
        GPU_REG_CLUTY = ~cy;
        req_texelAdress = ~adr;
        req_uSub = ~us;
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
    endtask

    task automatic serveRead(input string tag, input logic [18:0] expAdr,
                             input int delay, input logic [15:0] data);
        int n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_adr"}, 32'(mem_adr), 32'(expAdr));
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_hreq"}, 32'(mem_req), 32'd1);
            check({tag, "_hadr"}, 32'(mem_adr), 32'(expAdr));
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_noreq"}, 32'(mem_req), 32'd0);
        mem_dvalid = 1'b1;
        mem_data = data;
        tick();
        mem_dvalid = 1'b0;
        mem_data = 16'h0;
    endtask

    task automatic endOut(input string tag, input logic [15:0] color,
                          input int lat);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_vld"}, 32'(texel_valid), 32'd1);
        check({tag, "_col"}, 32'(texel_color), 32'(color));
        check({tag, "_oreq"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
        check({tag, "_vlo"}, 32'(texel_valid), 32'd0);
    endtask

    initial begin
        logic sawValid;
        #3;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mreq", 32'(mem_req), 32'd0);
        check("rst_madr", 32'(mem_adr), 32'd0);
        check("rst_tval", 32'(texel_valid), 32'd0);
        check("rst_tcol", 32'(texel_color), 32'd0);
        tick();
        i_nrst = 1'b1;
        tick();
        check("rel_ready", 32'(req_ready), 32'd1);

        // Stray memory strobes while idle must not start anything.
        mem_dvalid = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_dvalid = 1'b0;
        mem_ack = 1'b0;
        check("stray_req", 32'(mem_req), 32'd0);
        check("stray_vld", 32'(texel_valid), 32'd0);

        doReq("d16", 2'd2, 6'd0, 9'd0, 19'h12345, 2'd0);
        serveRead("d16t", 19'h12345, 0, 16'h7FFF);
        endOut("d16", 16'h7FFF, 4);

        doReq("i4", 2'd0, 6'd3, 9'h1F0, 19'h00400, 2'd2);
        serveRead("i4t", 19'h00400, 0, 16'hA5C3);
        serveRead("i4c", 19'h7C035, 0, 16'h4321);
        endOut("i4", 16'h4321, 6);

        doReq("i8w", 2'd1, 6'd63, 9'h005, 19'h7FFFF, 2'd1);
        serveRead("i8wt", 19'h7FFFF, 0, 16'hF012);
        serveRead("i8wc", 19'h014E0, 0, 16'h8ABC);
        endOut("i8w", 16'h8ABC, 6);

        doReq("i8l", 2'd1, 6'd2, 9'h000, 19'h00010, 2'd0);
        serveRead("i8lt", 19'h00010, 0, 16'h12AB);
        serveRead("i8lc", 19'h000CB, 0, 16'h0F0F);
        endOut("i8l", 16'h0F0F, 6);

        doReq("f3", 2'd3, 6'd5, 9'd5, 19'h40001, 2'd3);
        serveRead("f3t", 19'h40001, 0, 16'hBEEF);
        endOut("f3", 16'hBEEF, 4);

        doReq("stall", 2'd2, 6'd0, 9'd0, 19'h2A5A5, 2'd0);
        serveRead("stallt", 19'h2A5A5, 7, 16'h1234);
        check("stall_vld", 32'(texel_valid), 32'd1);
        tick();

        doReq("bp", 2'd2, 6'd0, 9'd0, 19'h00077, 2'd0);
        texel_ready = 1'b0;
        serveRead("bpt", 19'h00077, 0, 16'h5555);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", 32'(texel_valid), 32'd1);
            check("bp_col", 32'(texel_color), 32'h5555);
            check("bp_rdy", 32'(req_ready), 32'd0);
            check("bp_mreq", 32'(mem_req), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        texel_ready = 1'b1;
        tick();
        check("bp_rel", 32'(texel_valid), 32'd0);
        tick();
        check("bp_noacc", 32'(mem_req), 32'd0);

        doReq("rs", 2'd0, 6'd1, 9'd1, 19'h00100, 2'd0);
        serveRead("rst", 19'h00100, 0, 16'h0003);
        check("rs_cadr", 32'(mem_adr), 32'h00413);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        i_nrst = 1'b0;
        #1;
        check("rs_mreq", 32'(mem_req), 32'd0);
        check("rs_madr", 32'(mem_adr), 32'd0);
        check("rs_tval", 32'(texel_valid), 32'd0);
        check("rs_tcol", 32'(texel_color), 32'd0);
        tick();
        i_nrst = 1'b1;
        mem_dvalid = 1'b1;
        mem_data = 16'hFFFF;
        sawValid = 1'b0;
        tick();
        mem_dvalid = 1'b0;
        mem_data = 16'h0;
        for (int i = 0; i < 4; i++) begin
            if (texel_valid) sawValid = 1'b1;
            tick();
        end
        check("rs_never", 32'(sawValid), 32'd0);
        check("rs_ready", 32'(req_ready), 32'd1);
        check("rs_col", 32'(texel_color), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
